// File: rtl/md_pkg.sv
// md_pkg: shared encodings and constants for the md_seq multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: op encodings, FSM state enum, step count, divide-by-zero
// constant and a sign-aware absolute-value helper.
package md_pkg;

   // Operation encodings on the op port; codes 6 and 7 are no-ops.
   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MTHI  = 3'd4;
   localparam logic [2:0] MD_OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } md_state_t;

   // One radix-2 step per RUN cycle, so a full operation takes 32 RUN cycles.
   localparam int MD_STEPS = 32;
   localparam int MD_CNT_W = 5;

   // Divide by zero: LO saturates to all ones, HI returns the dividend.
   localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

   // Magnitude of v when treated as signed (sgn=1), otherwise v unchanged.
   // The most negative value maps onto itself, which is still the correct
   // unsigned magnitude 2^31.
   function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/md_div_step.sv
// md_div_step: one restoring shift-subtract division step (combinational).
// Latency: 0 cycles.
// Backpressure: none.
//
// Ports:
//   i_rem  partial remainder (always < i_dvs when i_dvs != 0)
//   i_bit  next dividend bit shifted into the remainder
//   i_dvs  divisor magnitude
//   o_rem  next partial remainder
//   o_q    quotient bit produced by this step
module md_div_step (
   input  logic [31:0] i_rem,
   input  logic        i_bit,
   input  logic [31:0] i_dvs,
   output logic [31:0] o_rem,
   output logic        o_q
);

   logic [32:0] w_shift;
   logic [32:0] w_trial;

   // The shifted remainder needs 33 bits; the trial subtraction borrows out
   // of bit 32 exactly when the divisor does not fit.
   assign w_shift = {i_rem, i_bit};
   assign w_trial = w_shift - {1'b0, i_dvs};

   always_comb begin
      o_q   = 1'b0;
      o_rem = w_shift[31:0];
      if (!w_trial[32]) begin
         o_q   = 1'b1;
         o_rem = w_trial[31:0];
      end
   end

endmodule

// File: rtl/md_seq.sv
// md_seq: iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Latency: 32 RUN + 1 FIX cycles after start; done pulses the cycle after FIX.
// Backpressure: busy high while not IDLE; starts while busy are dropped.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start, op, a, b   request (accepted only in IDLE), opcode, rs and rt operands
//   flush             abandons the in-flight operation, HI/LO untouched
//   busy, done        busy while not IDLE; one-cycle pulse when new HI/LO appear
//   hi, lo            registered HI and LO
//
// Build option: define MD_SEQ_EARLY_OUT_EN to end a multiply as soon as the
// remaining multiplier is zero. Divide latency and all results are unaffected.
module md_seq
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t           r_state;
   md_state_t           w_state_nxt;
   logic [MD_CNT_W-1:0] r_cnt;

   // Operation context captured at start.
   logic        r_is_mul;
   logic        r_neg_res;   // negate product / quotient in FIX
   logic        r_neg_rem;   // remainder takes the dividend's sign
   logic        r_div0;

   // Datapath. Multiply: r_acc accumulates, r_mcand shifts left, r_mplr
   // shifts right. Divide: r_acc[63:32] is the partial remainder and
   // r_acc[31:0] shifts dividend bits out of the top while quotient bits
   // enter at the bottom; r_mplr holds the divisor.
   logic [63:0] r_mcand;
   logic [31:0] r_mplr;
   logic [63:0] r_acc;

   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;

   // FSM control strobes.
   logic w_capture;
   logic w_step;
   logic w_write;
   logic w_mthi;
   logic w_mtlo;

   // Request decode.
   logic        w_is_md;
   logic        w_is_mul_op;
   logic        w_signed;
   logic [31:0] w_a_abs;
   logic [31:0] w_b_abs;

   assign w_is_mul_op = (op == MD_OP_MULT) || (op == MD_OP_MULTU);
   assign w_is_md     = w_is_mul_op || (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   assign w_signed    = (op == MD_OP_MULT) || (op == MD_OP_DIV);
   assign w_a_abs     = md_abs(a, w_signed);
   assign w_b_abs     = md_abs(b, w_signed);

   // One multiply step.
   logic [63:0] w_mul_acc;
   logic [31:0] w_mplr_nxt;

   assign w_mul_acc  = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mplr_nxt = {1'b0, r_mplr[31:1]};

   // One divide step.
   logic [31:0] w_div_rem;
   logic        w_div_q;
   logic [63:0] w_div_acc;

   md_div_step u_div_step (
      .i_rem (r_acc[63:32]),
      .i_bit (r_acc[31]),
      .i_dvs (r_mplr),
      .o_rem (w_div_rem),
      .o_q   (w_div_q)
   );

   assign w_div_acc = {w_div_rem, r_acc[30:0], w_div_q};

   // End-of-RUN conditions.
   logic w_last;
   logic w_early;

   assign w_last = (r_cnt == MD_CNT_W'(MD_STEPS - 1));

`ifdef MD_SEQ_EARLY_OUT_EN
   // Once the multiplier has no set bits left, further steps add nothing.
   assign w_early = r_is_mul && (w_mplr_nxt == 32'd0);
`else
   assign w_early = 1'b0;
`endif

   // FSM: state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state and control strobes. flush outranks start everywhere.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_step      = 1'b0;
      w_write     = 1'b0;
      w_mthi      = 1'b0;
      w_mtlo      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !flush) begin
               if (w_is_md) begin
                  w_capture   = 1'b1;
                  w_state_nxt = ST_RUN;
               end else if (op == MD_OP_MTHI) begin
                  w_mthi = 1'b1;
               end else if (op == MD_OP_MTLO) begin
                  w_mtlo = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (flush) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_step = 1'b1;
               if (w_last || w_early) begin
                  w_state_nxt = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            w_state_nxt = ST_IDLE;
            w_write     = !flush;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Sign correction applied while in FIX.
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   assign w_prod = r_neg_res ? (~r_acc + 64'd1) : r_acc;
   // With a zero divisor the restoring loop leaves |a| in the remainder, so
   // the normal remainder sign fix already reproduces a for HI; only LO
   // needs forcing.
   assign w_quo  = r_div0 ? MD_DIV0_LO
                 : (r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0]);
   assign w_rem  = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

   assign w_res_hi = r_is_mul ? w_prod[63:32] : w_rem;
   assign w_res_lo = r_is_mul ? w_prod[31:0]  : w_quo;

   // Operand capture and iteration datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_is_mul  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_mcand   <= '0;
         r_mplr    <= '0;
         r_acc     <= '0;
      end else if (w_capture) begin
         r_cnt     <= '0;
         r_is_mul  <= w_is_mul_op;
         r_neg_res <= w_signed && (a[31] ^ b[31]);
         r_neg_rem <= w_signed && a[31];
         r_div0    <= (b == 32'd0);
         r_mcand   <= {32'd0, w_a_abs};
         r_mplr    <= w_b_abs;
         r_acc     <= w_is_mul_op ? 64'd0 : {32'd0, w_a_abs};
      end else if (w_step) begin
         r_cnt <= r_cnt + MD_CNT_W'(1);
         if (r_is_mul) begin
            r_acc   <= w_mul_acc;
            r_mcand <= {r_mcand[62:0], 1'b0};
            r_mplr  <= w_mplr_nxt;
         end else begin
            r_acc <= w_div_acc;
         end
      end
   end

   // Architectural HI/LO and the done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_write;
         if (w_write) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else begin
            if (w_mthi) begin
               r_hi <= a;
            end
            if (w_mtlo) begin
               r_lo <= a;
            end
         end
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: directed self-checking bench for md_seq.
// Cycle c is sampled 1 time unit after the c-th rising edge following the
// edge that samples start; results must appear with done in cycle 34
// (steps + 2 for early-terminated multiplies).
module tb_md_seq;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef MD_SEQ_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_chk;
   int          n_err;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   md_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycle in which done is expected: 34, or steps + 2 for early-out multiplies.
   function automatic int exp_done(input logic [2:0] op_i, input logic [31:0] b_i);
      int          steps_eo;
      logic [31:0] mag;
      mag      = (op_i == OP_MULT && b_i[31]) ? (~b_i + 32'd1) : b_i;
      steps_eo = 1;
      for (int i = 0; i < 32; i++) begin
         if (mag[i]) steps_eo = i + 1;
      end
      if (EARLY && (op_i == OP_MULT || op_i == OP_MULTU)) return steps_eo + 2;
      return 34;
   endfunction

   // Issue one MULT/DIV op, optionally fire an ignored start in cycle inj_c,
   // and check latency, busy length, done pulse and the HI/LO result.
   task automatic run_op(input string nm, input logic [2:0] op_i,
                         input logic [31:0] a_i, input logic [31:0] b_i,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int inj_c, input logic [2:0] inj_op);
      int          nb;
      int          nd;
      int          dc;
      int          ed;
      logic [31:0] h_at;
      logic [31:0] l_at;
      ed    = exp_done(op_i, b_i);
      nb    = 0;
      nd    = 0;
      dc    = 0;
      h_at  = 'x;
      l_at  = 'x;
      start = 1'b1;
      op    = op_i;
      a     = a_i;
      b     = b_i;
      tick();
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      b     = 32'h1234_5678;
      for (int c = 1; c <= 40; c++) begin
         if (busy) nb++;
         if (done) begin
            nd++;
            if (dc == 0) begin
               dc   = c;
               h_at = hi;
               l_at = lo;
            end
         end
         if (c == inj_c) begin
            start = 1'b1;
            op    = inj_op;
            a     = 32'h5555_5555;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      chk({nm, "_busy_cycles"}, nb, ed - 1);
      chk({nm, "_done_cycle"}, dc, ed);
      chk({nm, "_done_count"}, nd, 1);
      chk({nm, "_hi"}, h_at, ehi);
      chk({nm, "_lo"}, l_at, elo);
      m_hi = ehi;
      m_lo = elo;
   endtask

   // MULTU with a 32-step multiplier, a second start (MTHI) in cycle 5 and
   // flush in cycle fc: busy must end after cycle fc, no done, HI/LO kept.
   task automatic flush_test(input string nm, input int fc);
      int nb;
      int nd;
      nb    = 0;
      nd    = 0;
      start = 1'b1;
      op    = OP_MULTU;
      a     = 32'd3;
      b     = 32'hFFFF_FFFF;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (busy) nb++;
         if (done) nd++;
         if (c == fc + 1) chk({nm, "_busy_after_flush"}, busy, 1'b0);
         start = (c == 5);
         if (c == 5) begin
            op = OP_MTHI;
            a  = 32'h99;
         end
         flush = (c == fc);
         tick();
      end
      flush = 1'b0;
      chk({nm, "_busy_cycles"}, nb, fc);
      chk({nm, "_no_done"}, nd, 0);
      chk({nm, "_hi_kept"}, hi, m_hi);
      chk({nm, "_lo_kept"}, lo, m_lo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = 3'd0;
      a     = 32'd0;
      b     = 32'd0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;

      #12;
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // MTHI / MTLO in IDLE.
      start = 1'b1;
      op    = OP_MTHI;
      a     = 32'hABCD;
      tick();
      start = 1'b0;
      chk("mthi_hi", hi, 32'hABCD);
      chk("mthi_lo", lo, 32'd0);
      chk("mthi_busy", busy, 1'b0);
      chk("mthi_done", done, 1'b0);
      start = 1'b1;
      op    = OP_MTHI;
      a     = 32'h11;
      tick();
      op    = OP_MTLO;
      a     = 32'h22;
      tick();
      start = 1'b0;
      chk("mt_pair_hi", hi, 32'h11);
      chk("mt_pair_lo", lo, 32'h22);
      m_hi = 32'h11;
      m_lo = 32'h22;

      // Flush mid-RUN and during FIX.
      flush_test("flush_run", 10);
      flush_test("flush_fix", 33);

      // flush and start together in IDLE: start is dropped.
      start = 1'b1;
      flush = 1'b1;
      op    = OP_MTHI;
      a     = 32'h77;
      tick();
      chk("flush_start_mthi", hi, m_hi);
      op = OP_MULT;
      a  = 32'd3;
      b  = 32'd3;
      tick();
      chk("flush_start_mult_busy", busy, 1'b0);
      start = 1'b0;
      flush = 1'b0;
      tick();
      chk("flush_start_mult_idle", busy, 1'b0);

      // Directed arithmetic vectors.
      run_op("mult_neg",    OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 2, OP_MULT);
      run_op("divu_100_7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        0, OP_MULT);
      run_op("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 3, OP_MTLO);
      run_op("div_by0",     OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 0, OP_MULT);
      run_op("div_neg_by0", OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, OP_MULT);
      run_op("divu_by0",    OP_DIVU,  32'h8000_0010, 32'd0,         32'h8000_0010, 32'hFFFF_FFFF, 0, OP_MULT);
      run_op("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0, OP_MULT);
      run_op("multu_5_3",   OP_MULTU, 32'd5,         32'd3,         32'd0,         32'd15,        0, OP_MULT);
      run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, OP_MULT);
      run_op("mult_min",    OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         0, OP_MULT);
      run_op("mult_by0",    OP_MULT,  32'h1234_5678, 32'd0,         32'd0,         32'd0,         0, OP_MULT);
      run_op("div_m7_m2",   OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         0, OP_MULT);

      // Asynchronous reset in cycle 20 of a 32-step multiply.
      start = 1'b1;
      op    = OP_MULTU;
      a     = 32'd3;
      b     = 32'hFFFF_FFFF;
      tick();
      start = 1'b0;
      for (int c = 1; c < 20; c++) tick();
      chk("rst_pre_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_done", done, 1'b0);
      chk("rst_mid_hi", hi, 32'd0);
      chk("rst_mid_lo", lo, 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("rst_after_busy", busy, 1'b0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      run_op("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, OP_MULT);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide port: start  input  1  request accepted only in IDLE.
REQ-004 SHALL provide port: op  input  3  MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; others are no-ops.
REQ-005 SHALL provide port: a  input  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
REQ-006 SHALL provide port: b  input  32  rt operand: multiplier or divisor.
REQ-007 SHALL provide port: flush  input  1  kills the in-flight operation.
REQ-008 SHALL provide port: busy  output  1  high while state is not IDLE; the pipeline stalls MFHI/MFLO/MDU instructions on it.
REQ-009 SHALL provide port: done  output  1  one-cycle pulse in the first cycle that a new HI/LO pair from MULT/DIV is visible.
REQ-010 SHALL provide port: hi  output  32  registered HI.
REQ-011 SHALL provide port: lo  output  32  registered LO.

Function
REQ-012 SHALL implement states IDLE, RUN and FIX.
REQ-013 IDLE SHALL go to RUN when start is high, flush is low and op is 0-3, capturing operands: absolute values for signed ops, sign flags, and step counter = 0.
REQ-014 RUN SHALL perform one radix-2 step per cycle: multiply uses a 64-bit left-shifting multiplicand and a right-shifting multiplier; divide uses restoring shift-subtract.
REQ-015 RUN SHALL go to FIX after step 31 (32 RUN cycles).
REQ-016 FIX SHALL, in one cycle, apply sign correction, write HI/LO on the clock edge that leaves FIX, and go to IDLE.
REQ-017 Latency SHALL be fixed: start sampled at edge 0; busy high in cycles 1-33; hi/lo updated at edge 34; done high in cycle 34, when busy is already low.
REQ-018 Multiply results SHALL be: HI = product[63:32], LO = product[31:0].
REQ-019 Divide results SHALL be: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
REQ-020 Divide by zero SHALL give LO = 0xFFFFFFFF and HI = a, for both DIV and DIVU.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-022 MTHI/MTLO with start high in IDLE SHALL write hi/lo at the next edge with no busy and no done.
REQ-023 start while busy SHALL be ignored for every op, including MTHI/MTLO.
REQ-024 flush while busy SHALL return to IDLE at the next edge, leave hi/lo unchanged and suppress done.
REQ-025 When flush and start are both high in the same cycle, flush SHALL win and start SHALL be ignored.
REQ-026 Operand inputs SHALL be don't-care after capture.

Reset
REQ-027 rst_n low SHALL immediately force state = IDLE, busy = 0, done = 0, hi = 0, lo = 0 and counter = 0, including mid-operation.
REQ-028 The first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-029 Macro MD_SEQ_EARLY_OUT_EN SHALL control multiply early termination.
REQ-030 With MD_SEQ_EARLY_OUT_EN defined, RUN SHALL go to FIX at the edge after any multiply step that leaves the remaining multiplier at zero, so MULT/MULTU latency = steps + 2.
REQ-031 With MD_SEQ_EARLY_OUT_EN defined, divide latency SHALL be unchanged.
REQ-032 Without MD_SEQ_EARLY_OUT_EN, all operations SHALL have the fixed latency of REQ-017.
REQ-033 Results SHALL be identical with and without MD_SEQ_EARLY_OUT_EN.

Structure
REQ-034 Package md_pkg SHALL hold the op encodings, the state enum, the step count constant 32 and the divide-by-zero result constants.
REQ-035 The one combinational sub-module SHALL be md_div_step: one restoring step, with inputs partial remainder, dividend bit and divisor, and outputs next remainder and quotient bit.

Verification
REQ-036 MULT a=0xFFFFFFFD, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB at edge 34; busy high for exactly 33 cycles; done a single pulse.
REQ-037 DIVU a=100, b=7 -> lo=14, hi=2; DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=5; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 MULTU started with hi/lo = 0x11/0x22, second start in cycle 5, flush in cycle 10 -> busy low from cycle 11, hi/lo stay 0x11/0x22, no done, second start ignored.
REQ-040 MTHI a=0xABCD in IDLE -> hi=0xABCD next cycle with busy staying 0; MTLO during a DIV -> ignored; rst_n low in cycle 20 of a MULT -> all outputs 0 immediately.
REQ-041 With MD_SEQ_EARLY_OUT_EN defined, MULTU a=5, b=3 -> lo=15, hi=0, done in cycle 4; without the macro, done in cycle 34.
